// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide execute unit with pipeline stall
//
// Ports:
//   clk         in   1     core clock, rising edge
//   reset       in   1     synchronous active-high reset
//   Start       in   1     request, sampled only while idle
//   ALUControl  in   4     4'b0010 = MUL (low XLEN bits), 4'b0100 = DIV (signed quotient)
//   SrcA        in   XLEN  multiplicand / dividend
//   SrcB        in   XLEN  multiplier / divisor
//   Busy        out  1     high while running and in the done cycle
//   Done        out  1     one-cycle pulse, Result valid in that cycle
//   Stall       out  1     holds the pipeline from the accept cycle through the done cycle
//   Result      out  XLEN  product low half or quotient, held until the next op completes
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            Busy,
    output logic            Done,
    output logic            Stall,
    output logic [XLEN-1:0] Result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            op_div_q;
    logic            neg_q;
    // a_q: multiplicand (MUL) or dividend shifting out / quotient shifting in (DIV)
    // b_q: multiplier (MUL) or divisor magnitude (DIV)
    // acc_q: product accumulator (MUL) or partial remainder (DIV)
    logic [XLEN-1:0] a_q, b_q, acc_q;
    logic [XLEN-1:0] result_q;

    logic            is_mul_in, is_div_in, valid_op, accept;
    logic            div_zero, div_ovf, special;
    logic            last_iter;
    logic [XLEN-1:0] abs_a, abs_b;

    assign is_mul_in = (ALUControl == 4'b0010);
    assign is_div_in = (ALUControl == 4'b0100);
    assign valid_op  = is_mul_in | is_div_in;
    assign accept    = (state_q == S_IDLE) & Start & valid_op;
    assign div_zero  = (SrcB == '0);
    assign div_ovf   = (SrcA == MIN_NEG) & (SrcB == '1);
    // Special-case divides are resolved at accept and go straight to DONE.
    assign special   = is_div_in & (div_zero | div_ovf);
    assign last_iter = (cnt_q == LAST_CNT);

    // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign abs_a = SrcA[XLEN-1] ? -SrcA : SrcA;
    assign abs_b = SrcB[XLEN-1] ? -SrcB : SrcB;

    // One iteration step for each operation.
    logic [XLEN-1:0] mul_acc;
    logic [XLEN:0]   rem_sh, rem_diff;
    logic            q_bit;
    logic [XLEN-1:0] div_rem, div_quo, div_final;

    always_comb begin
        mul_acc   = acc_q + (b_q[0] ? a_q : '0);
        rem_sh    = {acc_q, a_q[XLEN-1]};
        rem_diff  = rem_sh - {1'b0, b_q};
        q_bit     = ~rem_diff[XLEN];
        div_rem   = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        div_quo   = {a_q[XLEN-2:0], q_bit};
        div_final = neg_q ? -div_quo : div_quo;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = special ? S_DONE : S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state_q)
            S_RUN:   Busy = 1'b1;
            S_DONE: begin
                Busy = 1'b1;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

    assign Stall  = Busy | accept;
    assign Result = result_q;

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        op_div_q <= is_div_in;
                        if (is_div_in) begin
                            a_q   <= abs_a;
                            b_q   <= abs_b;
                            neg_q <= SrcA[XLEN-1] ^ SrcB[XLEN-1];
                            if (div_zero) begin
                                result_q <= '1;
                            end else if (div_ovf) begin
                                result_q <= MIN_NEG;
                            end
                        end else begin
                            a_q   <= SrcA;
                            b_q   <= SrcB;
                            neg_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (op_div_q) begin
                        acc_q <= div_rem;
                        a_q   <= div_quo;
                    end else begin
                        acc_q <= mul_acc;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                    end
                    // Capture the final step directly so Result is valid in the DONE cycle.
                    if (last_iter) begin
                        result_q <= op_div_q ? div_final : mul_acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard testbench for mdu_iter
module tb_mdu_iter;

    localparam int XLEN = 32;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam int LAT_RUN = XLEN + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            Start;
    logic [3:0]      ALUControl;
    logic [XLEN-1:0] SrcA, SrcB;
    logic            Busy, Done, Stall;
    logic [XLEN-1:0] Result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [XLEN-1:0] exp_q[$];

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Busy       (Busy),
        .Done       (Done),
        .Stall      (Stall),
        .Result     (Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Caller positions us mid-cycle in IDLE (or DONE for the no-accept case).
    task automatic run_op(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        int n;
        logic stall_ok;
        logic [XLEN-1:0] want;
        Start      = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        exp_q.push_back(exp);
        #1;
        check({tag, "_stall_accept"}, {31'b0, Stall}, 32'd1);
        @(posedge clk);
        #1;
        // Operand churn while busy must not disturb the latched op.
        Start      = 1'b0;
        ALUControl = 4'b0100;
        SrcA       = $urandom;
        SrcB       = $urandom;
        stall_ok   = 1'b1;
        n          = 0;
        do begin
            @(negedge clk);
            n++;
            if (!Done && !Stall) stall_ok = 1'b0;
        end while (!Done && n < 100);
        check({tag, "_latency"}, n, lat);
        check({tag, "_stall_run"}, {31'b0, stall_ok}, 32'd1);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check({tag, "_result"}, Result, want);
        end
    endtask

    initial begin
        logic [XLEN-1:0] a, b, e;
        logic seen_done;

        reset      = 1'b1;
        Start      = 1'b0;
        ALUControl = 4'b0000;
        SrcA       = '0;
        SrcB       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",   {31'b0, Busy},  32'd0);
        check("reset_done",   {31'b0, Done},  32'd0);
        check("reset_stall",  {31'b0, Stall}, 32'd0);
        check("reset_result", Result,         32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 32'd42, LAT_RUN);
        @(negedge clk);
        run_op("mul_ffx2", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, LAT_RUN);

        // Start raised in the DONE cycle: not taken there, taken next cycle in IDLE.
        Start      = 1'b1;
        ALUControl = OP_MUL;
        SrcA       = 32'd3;
        SrcB       = 32'd5;
        @(posedge clk);
        #1;
        check("done_no_accept_busy", {31'b0, Busy}, 32'd0);
        check("done_no_accept_done", {31'b0, Done}, 32'd0);
        run_op("mul_3x5_reaccept", OP_MUL, 32'd3, 32'd5, 32'd15, LAT_RUN);
        @(negedge clk);

        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_RUN);
        @(negedge clk);
        run_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT_RUN);
        @(negedge clk);
        run_op("div_by0", OP_DIV, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
        @(negedge clk);
        check("hold_after_done", Result, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        @(negedge clk);

        // Unsupported code is ignored.
        Start      = 1'b1;
        ALUControl = 4'b0110;
        SrcA       = 32'd9;
        SrcB       = 32'd9;
        #1;
        check("badop_stall", {31'b0, Stall}, 32'd0);
        @(posedge clk);
        #1;
        check("badop_busy",   {31'b0, Busy}, 32'd0);
        check("badop_result", Result,        32'h8000_0000);
        Start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 0) b = 32'hFFFF_FFFF;
            e = a * b;
            run_op("mul_rand", OP_MUL, a, b, e, LAT_RUN);
            @(negedge clk);
            a = $urandom;
            b = (i < 3) ? XLEN'($urandom_range(1, 50)) : $urandom;
            if (i == 1) b = -b;
            if (b == '0) b = 32'd1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            e = $signed(a) / $signed(b);
            run_op("div_rand", OP_DIV, a, b, e, LAT_RUN);
            @(negedge clk);
        end

        // Reset while running with counter at 10 aborts the op silently.
        Start      = 1'b1;
        ALUControl = OP_MUL;
        SrcA       = 32'd7;
        SrcB       = 32'd6;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",   {31'b0, Busy}, 32'd0);
        check("abort_done",   {31'b0, Done}, 32'd0);
        check("abort_result", Result,        32'd0);
        reset     = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (Done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'b0, seen_done}, 32'd0);

        run_op("mul_after_abort", OP_MUL, 32'd9, 32'd9, 32'd81, LAT_RUN);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
